cascade_inta_sequencer: RTL and testbench

- Clocked controller that sequences the two-pulse interrupt-acknowledge (INTA) cycle of the PIC across the cascade bus.
- In master mode (SPEN=1) it latches the winning IR level and drives its ID onto CAS for the whole acknowledge when that IR hosts a slave.
- In slave mode (SPEN=0) it compares CAS against its own ID and takes the data bus on the second pulse only when selected.
- Sits between the priority resolver / ISR logic, the cascade pins and the data-bus output buffer.

---
 rtl/pic_pkg.sv | 32 +++
 rtl/inta_edge_sync.sv | 37 +++
 rtl/cascade_inta_sequencer.sv | 140 ++++++++++++++
 tb/tb_cascade_inta_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types and constants for the PIC acknowledge path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pic_pkg;

  localparam int IR_W = 8;
  localparam int ID_W = 3;

  localparam logic [ID_W-1:0] SPURIOUS_LVL_C = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    GAP  = 2'd2,
    P2   = 2'd3
  } inta_state_t;

  // Vector byte is a plain concatenation of the ICW2 base and the IR level.
  function automatic logic [IR_W-1:0] make_vector(
    input logic [IR_W-ID_W-1:0] base,
    input logic [ID_W-1:0]      lvl
  );
    return {base, lvl};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inta_edge_sync.sv
// ============================================================================
//  Module      : inta_edge_sync
//  Description : INTA_N synchronizer with single-cycle fall/rise pulses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  // Strobe idles high, so every stage resets to 1 to avoid a false edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];
  assign rise = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/cascade_inta_sequencer.sv
// ============================================================================
//  Module      : cascade_inta_sequencer
//  Description : Sequences the two-pulse INTA cycle over the cascade bus.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cascade_inta_sequencer
  import pic_pkg::*;
#(
  parameter int              SYNC_STAGES  = 2,
  parameter logic [ID_W-1:0] SPURIOUS_LVL = SPURIOUS_LVL_C
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spen,
  input  logic [IR_W-1:0]      slave_map,
  input  logic [ID_W-1:0]      slave_id,
  input  logic [IR_W-ID_W-1:0] vec_base,
  input  logic                 int_req,
  input  logic [ID_W-1:0]      int_level,
  input  logic                 inta_n,
  input  logic [ID_W-1:0]      cas_in,
  output logic [ID_W-1:0]      cas_out,
  output logic                 cas_oe,
  output logic [IR_W-1:0]      data_out,
  output logic                 data_oe,
  output logic                 intr,
  output logic                 isr_set,
  output logic [ID_W-1:0]      isr_lvl
);

  logic fall;
  logic rise;

  inta_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  inta_state_t     state;
  logic            mode_q;
  logic            spur_q;
  logic            casc_q;
  logic            sel_q;
  logic [ID_W-1:0] lvl_q;

  logic [ID_W-1:0] lvl_in;
  logic            casc_in;
  logic            sel_in;
  logic [IR_W-1:0] vector;

  assign lvl_in  = int_req ? int_level : SPURIOUS_LVL;
  assign casc_in = spen & int_req & slave_map[lvl_in];
  assign sel_in  = (cas_in == slave_id);
  assign vector  = make_vector(vec_base, lvl_q);

  assign intr = int_req && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= 1'b0;
      spur_q   <= 1'b0;
      casc_q   <= 1'b0;
      sel_q    <= 1'b0;
      lvl_q    <= '0;
      cas_out  <= '0;
      cas_oe   <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      isr_set  <= 1'b0;
      isr_lvl  <= '0;
    end else begin
      isr_set <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= P1;
            mode_q  <= spen;
            lvl_q   <= lvl_in;
            spur_q  <= ~int_req;
            casc_q  <= casc_in;
            sel_q   <= 1'b0;
            cas_oe  <= casc_in;
            cas_out <= casc_in ? lvl_in : '0;
            // The master owns the ISR update on the first pulse.
            if (spen && int_req) begin
              isr_set <= 1'b1;
              isr_lvl <= lvl_in;
            end
          end
        end
        P1: begin
          if (rise) begin
            state <= GAP;
          end
        end
        GAP: begin
          if (fall) begin
            state <= P2;
            if (mode_q) begin
              data_oe  <= ~casc_q;
              data_out <= casc_q ? '0 : vector;
            end else begin
              // CAS is sampled exactly once, here; later bus activity is ignored.
              sel_q    <= sel_in;
              data_oe  <= sel_in;
              data_out <= sel_in ? vector : '0;
              if (sel_in && !spur_q) begin
                isr_set <= 1'b1;
                isr_lvl <= lvl_q;
              end
            end
          end
        end
        P2: begin
          if (rise) begin
            state    <= IDLE;
            data_oe  <= 1'b0;
            data_out <= '0;
            cas_oe   <= 1'b0;
            cas_out  <= '0;
          end else begin
            data_oe <= mode_q ? ~casc_q : sel_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cascade_inta_sequencer.sv
// Randomized scoreboard bench: per-acknowledge expectations are queued by the
// stimulus and reconciled by an independent output monitor.
`default_nettype none

module tb_cascade_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spen;
  logic [7:0] slave_map;
  logic [2:0] slave_id;
  logic [4:0] vec_base;
  logic       int_req;
  logic [2:0] int_level;
  logic       inta_n;
  logic [2:0] cas_in;
  logic [2:0] cas_out;
  logic       cas_oe;
  logic [7:0] data_out;
  logic       data_oe;
  logic       intr;
  logic       isr_set;
  logic [2:0] isr_lvl;

  cascade_inta_sequencer #(
    .SYNC_STAGES  (2),
    .SPURIOUS_LVL (3'd7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spen      (spen),
    .slave_map (slave_map),
    .slave_id  (slave_id),
    .vec_base  (vec_base),
    .int_req   (int_req),
    .int_level (int_level),
    .inta_n    (inta_n),
    .cas_in    (cas_in),
    .cas_out   (cas_out),
    .cas_oe    (cas_oe),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .intr      (intr),
    .isr_set   (isr_set),
    .isr_lvl   (isr_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         isr_n;
    logic [2:0] isr_lvl;
    int         cas_cyc;
    logic [2:0] cas_val;
    int         data_cyc;
    logic [7:0] data_val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endfunction

  // Monitor: accumulate what the DUT presents, reconcile once per acknowledge.
  initial begin
    int         isr_n;
    int         cas_cyc;
    int         data_cyc;
    int         cas_bad;
    int         data_bad;
    int         seen;
    logic [2:0] isr_l;
    exp_t       e;
    isr_n = 0; cas_cyc = 0; data_cyc = 0; cas_bad = 0; data_bad = 0;
    seen = 0; isr_l = 3'd0;
    forever begin
      @(negedge clk);
      if (isr_set) begin
        isr_n++;
        isr_l = isr_lvl;
      end
      if (cas_oe) begin
        cas_cyc++;
        if (exp_q.size() > 0 && cas_out != exp_q[0].cas_val) cas_bad++;
      end else if (cas_out != 3'd0) begin
        cas_bad++;
      end
      if (data_oe) begin
        data_cyc++;
        if (exp_q.size() > 0 && data_out != exp_q[0].data_val) data_bad++;
      end else if (data_out != 8'd0) begin
        data_bad++;
      end
      if (done_cnt != seen) begin
        seen++;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("isr_pulses", isr_n, e.isr_n);
          check("isr_lvl", int'(isr_l), int'(e.isr_lvl));
          check("cas_oe_cycles", cas_cyc, e.cas_cyc);
          check("cas_out_value_errs", cas_bad, 0);
          check("data_oe_cycles", data_cyc, e.data_cyc);
          check("data_out_value_errs", data_bad, 0);
        end
        isr_n = 0; cas_cyc = 0; data_cyc = 0; cas_bad = 0; data_bad = 0;
        isr_l = 3'd0;
      end
    end
  end

  // One acknowledge: w1 low, g high, w2 low (in clocks). Optional mid-cycle
  // perturbation of request/mode, or an abort by reset during the gap.
  task automatic run_ack(input bit sp, input logic [7:0] map, input logic [2:0] id,
                         input logic [2:0] cin, input logic [4:0] vb, input bit req,
                         input logic [2:0] lvl, input int w1, input int g, input int w2,
                         input bit perturb, input bit abort);
    exp_t       e;
    logic [2:0] l;
    bit         casc;
    bit         sel;
    int         total;
    @(negedge clk);
    spen = sp; slave_map = map; slave_id = id; cas_in = cin;
    vec_base = vb; int_req = req; int_level = lvl; inta_n = 1'b1;
    l     = req ? lvl : 3'd7;
    casc  = sp && req && map[l];
    sel   = (cin == id);
    total = w1 + g + w2;
    e.cas_val  = l;
    e.data_val = {vb, l};
    if (sp) begin
      e.isr_n    = req ? 1 : 0;
      e.cas_cyc  = casc ? total : 0;
      e.data_cyc = casc ? 0 : w2;
    end else begin
      e.isr_n    = (sel && req) ? 1 : 0;
      e.cas_cyc  = 0;
      e.data_cyc = sel ? w2 : 0;
    end
    e.isr_lvl = (e.isr_n != 0) ? l : 3'd0;
    if (abort) e.data_cyc = 0;
    exp_q.push_back(e);
    @(negedge clk);
    check("int_idle", int'(intr), int'(req));
    for (int c = 0; c < total; c++) begin
      if (c == 3) check("int_during_ack", int'(intr), 0);
      if (perturb && c == w1 + 3) begin
        spen      = ~spen;
        int_level = int_level + 3'd2;
        int_req   = ~int_req;
      end
      if (c == w1 + g + 3) cas_in = ~cin;
      inta_n = (c < w1 || c >= w1 + g) ? 1'b0 : 1'b1;
      if (abort && c == w1 + 5) begin
        #2 rst_n = 1'b0;
        #1 check("reset_outputs_zero",
                 int'({cas_out, cas_oe, data_out, data_oe, isr_set, isr_lvl}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
    end
    inta_n = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    done_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; spen = 1'b1; slave_map = 8'h00; slave_id = 3'd0; vec_base = 5'h00;
    int_req = 1'b0; int_level = 3'd0; inta_n = 1'b1; cas_in = 3'd0;
    #12;
    check("reset_state",
          int'({cas_out, cas_oe, data_out, data_oe, intr, isr_set, isr_lvl}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_ack(1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1, 3'd3, 2, 3, 3, 1'b0, 1'b0);
    run_ack(1'b1, 8'h04, 3'd0, 3'd0, 5'h08, 1'b1, 3'd2, 3, 2, 4, 1'b0, 1'b0);
    run_ack(1'b0, 8'h00, 3'd2, 3'd2, 5'h10, 1'b1, 3'd5, 2, 3, 4, 1'b0, 1'b0);
    run_ack(1'b0, 8'h00, 3'd2, 3'd6, 5'h10, 1'b1, 3'd5, 2, 3, 4, 1'b0, 1'b0);
    run_ack(1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b0, 3'd3, 2, 3, 3, 1'b0, 1'b0);
    run_ack(1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1, 3'd1, 2, 8, 3, 1'b0, 1'b1);
    run_ack(1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1, 3'd1, 2, 3, 3, 1'b0, 1'b0);
    run_ack(1'b1, 8'h10, 3'd0, 3'd0, 5'h08, 1'b1, 3'd4, 2, 4, 3, 1'b1, 1'b0);
    run_ack(1'b1, 8'h00, 3'd0, 3'd0, 5'h08, 1'b1, 3'd4, 2, 4, 3, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] id;
      logic [2:0] cin;
      id  = 3'($urandom);
      cin = ($urandom_range(0, 1) == 1) ? id : 3'($urandom);
      run_ack(1'($urandom_range(0, 1)), 8'($urandom), id, cin, 5'($urandom),
              ($urandom_range(0, 3) != 0), 3'($urandom),
              $urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 5),
              1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
